// File: rtl/arithmetic_divider32_if.sv
// Request/result bundle for the multi-cycle divider: start/busy/done handshake,
// operands in, quotient/remainder/div_by_zero out.
interface arithmetic_divider32_if #(
    parameter int WIDTH = 32
);
    // Handshake: start is sampled only while the divider is idle; busy is high
    // while an accepted request is in flight; done pulses for one cycle when the
    // results become valid; results then hold until the next accepted start.
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, is_signed, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, is_signed, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/arithmetic_divider32.sv
// Radix-2 restoring divider on operand magnitudes with RISC-V DIV/DIVU/REM/REMU
// sign rules; one quotient bit per cycle, sign fix-up in a separate cycle.
module arithmetic_divider32 #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    arithmetic_divider32_if.slave  bus,
    output logic [1:0]             o_dbg_state
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_dvsr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sign_q;
    logic             r_sign_r;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_remd;
    logic             r_dbz;

    logic             w_dvd_neg;
    logic             w_dvs_neg;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;

    assign w_dvd_neg = bus.is_signed & bus.dividend[WIDTH-1];
    assign w_dvs_neg = bus.is_signed & bus.divisor[WIDTH-1];
    assign w_dvd_mag = w_dvd_neg ? -bus.dividend : bus.dividend;
    assign w_dvs_mag = w_dvs_neg ? -bus.divisor  : bus.divisor;

    // Partial remainder stays below the divisor, so WIDTH+1 bits hold the
    // shifted value and the trial's borrow bit tells whether it went negative.
    assign w_shift = {r_rem, r_q[WIDTH-1]};
    assign w_trial = w_shift - {1'b0, r_dvsr};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_rem    <= '0;
            r_q      <= '0;
            r_dvsr   <= '0;
            r_cnt    <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_quot   <= '0;
            r_remd   <= '0;
            r_dbz    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (bus.divisor == '0) begin
                            r_quot  <= '1;
                            r_remd  <= bus.dividend;
                            r_dbz   <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_q      <= w_dvd_mag;
                            r_dvsr   <= w_dvs_mag;
                            r_rem    <= '0;
                            r_sign_q <= w_dvd_neg ^ w_dvs_neg;
                            r_sign_r <= w_dvd_neg;
                            r_cnt    <= CNT_W'(WIDTH);
                            r_busy   <= 1'b1;
                            r_state  <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    r_rem <= w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
                    r_q   <= {r_q[WIDTH-2:0], ~w_trial[WIDTH]};
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_quot  <= r_sign_q ? -r_q : r_q;
                    r_remd  <= r_sign_r ? -r_rem : r_rem;
                    r_dbz   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.quotient    = r_quot;
    assign bus.remainder   = r_remd;
    assign bus.div_by_zero = r_dbz;
    assign o_dbg_state     = r_state;
endmodule

// File: doc/arithmetic_divider32.md
Name: arithmetic_divider32

Overview:
Multi-cycle 32-bit integer divider that sits beside the single-cycle add/sub/set-less-than arithmetic unit in the execute stage, covering the division direction that unit lacks. It accepts a request with a start/busy/done handshake, performs radix-2 restoring division on operand magnitudes, and returns quotient and remainder with sign correction. Signed and unsigned modes follow RISC-V DIV/DIVU/REM/REMU result rules.

Parameters:
WIDTH, 32, operand, quotient and remainder width. Only 32 is verified.
CNT_W, 6, iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request strobe; sampled only in IDLE
is_signed  input  1  1 = two's-complement operands, 0 = unsigned
dividend  input  WIDTH  numerator, sampled with start
divisor  input  WIDTH  denominator, sampled with start
busy  output  1  high from the cycle after start acceptance until done
done  output  1  one-cycle pulse; results valid in this cycle
quotient  output  WIDTH  result quotient, held until the next accepted start
remainder  output  WIDTH  result remainder, held until the next accepted start
div_by_zero  output  1  set with done when divisor == 0, held with results

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE; busy, done and div_by_zero = 0; quotient, remainder, internal registers and counter = 0.
- Reset mid-operation: abort immediately to IDLE with all outputs at reset values. No done pulse is produced for the aborted request.
- States: IDLE, RUN, FIX, DONE.
- IDLE, start=1, divisor!=0:
  - Latch |dividend| and |divisor|. Absolute value applies only when is_signed=1 and the MSB is set.
  - Latch sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend), both 0 when unsigned.
  - Clear partial remainder, set counter=WIDTH, go to RUN.
- IDLE, start=1, divisor==0: go to DONE next cycle with quotient=all ones, remainder=dividend (unmodified) and div_by_zero=1.
- RUN, one iteration per cycle:
  - Shift {rem,q} left by 1.
  - trial = rem - divisor_mag, computed WIDTH+1 bits wide.
  - If trial is non-negative, rem=trial and q[0]=1; otherwise q[0]=0.
  - Decrement counter. When counter reaches 0 after the update, go to FIX.
- FIX: quotient = sign_q ? -q : q; remainder = sign_r ? -rem : rem. Go to DONE.
- DONE: done=1 for exactly this cycle, busy=0. Return to IDLE next cycle.
- Latency:
  - Normal path: start accepted in cycle 0, RUN in cycles 1..32, FIX in cycle 33, done in cycle 34.
  - Divide-by-zero path: done in cycle 1.
- busy is 1 in RUN and FIX, 0 in IDLE and DONE.
- start while not in IDLE (including the DONE cycle) is ignored and has no effect on the in-flight result.
- Signed overflow, -2^31 / -1: quotient=0x80000000, remainder=0, div_by_zero=0. This falls out of the magnitude path because |-2^31| = 0x80000000 unsigned; no special case is permitted to change it.
- Magnitude arithmetic is unsigned throughout. Negation is two's complement modulo 2^WIDTH.
- The remainder sign always follows the dividend, and |remainder| < |divisor|.
- Outputs and div_by_zero change only on DONE entry or reset. Results persist through IDLE until the next accepted start.
- Operands may change after the start cycle without affecting the result.

Test Plan:
- Unsigned 100 / 7, is_signed=0 -> done exactly 34 cycles after start; quotient=14, remainder=2, div_by_zero=0; busy high for cycles 1..33.
- Signed -7 / 2 -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). Signed 7 / -2 -> quotient=-3, remainder=1.
- Divide by zero, 0x00001234 / 0 (both modes) -> done 1 cycle after start; quotient=0xFFFFFFFF, remainder=0x00001234, div_by_zero=1.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0. The same operands unsigned -> quotient=0, remainder=0x80000000.
- Start 0xFFFFFFFF / 1 unsigned, pulse start with 5/5 at cycle 10 and again in the DONE cycle -> single done with quotient=0xFFFFFFFF, remainder=0; the second and third requests are ignored.
- Assert rst_n=0 at cycle 15 of a 1000/3 run -> outputs zero asynchronously and no done pulse. A fresh 1000/3 then yields quotient=333, remainder=1 at cycle 34.
